// File: rtl/regfile_arb_swc.sv
// Register-file front end: two write requesters share one write port under round-robin
// arbitration, and a single-outstanding read path has RAW-hazard stalling.
module regfile_arb_swc #(
  parameter int RF_AW = 5,
  parameter int RF_DW = 32
) (
  input  logic             hclk,
  input  logic             hrstn,
  input  logic             wr0_valid,
  output logic             wr0_ready,
  input  logic [RF_AW-1:0] wr0_addr,
  input  logic [RF_DW-1:0] wr0_data,
  input  logic             wr1_valid,
  output logic             wr1_ready,
  input  logic [RF_AW-1:0] wr1_addr,
  input  logic [RF_DW-1:0] wr1_data,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [RF_AW-1:0] rd_addr1,
  input  logic [RF_AW-1:0] rd_addr2,
  input  logic             rd_en1,
  input  logic             rd_en2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RF_DW-1:0] rsp_data1,
  output logic [RF_DW-1:0] rsp_data2,
  output logic             reg_wen,
  output logic [RF_AW-1:0] reg_waddr,
  output logic [RF_DW-1:0] reg_wdata,
  output logic             reg_ren_1,
  output logic             reg_ren_2,
  output logic [RF_AW-1:0] reg_raddr_1,
  output logic [RF_AW-1:0] reg_raddr_2,
  input  logic [RF_DW-1:0] reg_rdata_1,
  input  logic [RF_DW-1:0] reg_rdata_2,
  output logic [15:0]      wr_conflict_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} rd_state_e;

  rd_state_e        state_q;
  logic             prio_q;   // requester favoured when both are valid
  logic [15:0]      cnt_q;
  logic             en1_q, en2_q;
  logic             rsp_valid_q;
  logic [RF_DW-1:0] rsp_data1_q, rsp_data2_q;

  logic gnt0, gnt1, haz1, haz2, rd_fire;

  always_comb begin
    gnt0 = hrstn && wr0_valid && (!wr1_valid || !prio_q);
    gnt1 = hrstn && wr1_valid && (!wr0_valid || prio_q);
    // A granted write to the same address is forwarded by the regfile bypass, so only losers stall
    haz1 = rd_en1 && (rd_addr1 != '0) &&
           ((wr0_valid && (wr0_addr == rd_addr1) && !gnt0) ||
            (wr1_valid && (wr1_addr == rd_addr1) && !gnt1));
    haz2 = rd_en2 && (rd_addr2 != '0) &&
           ((wr0_valid && (wr0_addr == rd_addr2) && !gnt0) ||
            (wr1_valid && (wr1_addr == rd_addr2) && !gnt1));
    rd_ready = hrstn && (state_q == S_IDLE) && !haz1 && !haz2;
    rd_fire  = rd_valid && rd_ready;

    wr0_ready = gnt0;
    wr1_ready = gnt1;
    reg_wen   = 1'b0;
    reg_waddr = '0;
    reg_wdata = '0;
    if (gnt0 && (wr0_addr != '0)) begin
      reg_wen   = 1'b1;
      reg_waddr = wr0_addr;
      reg_wdata = wr0_data;
    end else if (gnt1 && (wr1_addr != '0)) begin
      reg_wen   = 1'b1;
      reg_waddr = wr1_addr;
      reg_wdata = wr1_data;
    end

    reg_ren_1   = 1'b0;
    reg_ren_2   = 1'b0;
    reg_raddr_1 = '0;
    reg_raddr_2 = '0;
    if (rd_fire) begin
      reg_ren_1   = rd_en1;
      reg_ren_2   = rd_en2;
      reg_raddr_1 = rd_addr1;
      reg_raddr_2 = rd_addr2;
    end
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      state_q     <= S_IDLE;
      prio_q      <= 1'b0;
      cnt_q       <= '0;
      en1_q       <= 1'b0;
      en2_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data1_q <= '0;
      rsp_data2_q <= '0;
    end else begin
      if (gnt0)      prio_q <= 1'b1;
      else if (gnt1) prio_q <= 1'b0;

      if (wr0_valid && wr1_valid && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;

      case (state_q)
        S_IDLE: if (rd_fire) begin
          en1_q   <= rd_en1;
          en2_q   <= rd_en2;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          rsp_data1_q <= en1_q ? reg_rdata_1 : '0;
          rsp_data2_q <= en2_q ? reg_rdata_2 : '0;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid       = rsp_valid_q;
  assign rsp_data1       = rsp_data1_q;
  assign rsp_data2       = rsp_data2_q;
  assign wr_conflict_cnt = cnt_q;

endmodule
